// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator execution stage and its data register:
// opcode values, FSM state encoding and default datapath widths.
package cpu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AW    = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_MUL = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hA;
    localparam logic [3:0] OP_CLR = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MUL
    } state_t;

    // NOP, OUT and the unused codes C-F leave the accumulator and flags alone.
    function automatic logic writesAcc(input logic [3:0] op);
        return ((op >= OP_LDA) && (op <= OP_SHR)) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/accumulator_alu.sv
// Combinational single-cycle ALU: computes the new accumulator value and carry
// for every opcode except MUL, which is iterated by the top-level FSM.
module accumulator_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_acc} + {1'b0, i_operand};

    // Non-writing opcodes pass the accumulator through with carry cleared.
    always_comb begin
        o_result = i_acc;
        o_carry  = 1'b0;
        case (i_op)
            OP_LDA: o_result = i_operand;
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                o_result = i_acc - i_operand;
                o_carry  = (i_acc < i_operand);
            end
            OP_AND: o_result = i_acc & i_operand;
            OP_OR:  o_result = i_acc | i_operand;
            OP_XOR: o_result = i_acc ^ i_operand;
            OP_SHL: begin
                o_result = {i_acc[WIDTH-2:0], 1'b0};
                o_carry  = i_acc[WIDTH-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_acc[WIDTH-1:1]};
                o_carry  = i_acc[0];
            end
            OP_CLR: o_result = '0;
            default: begin
                o_result = i_acc;
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/accumulator_unit.sv
// Accumulator execution stage: fetches an operand from the data register,
// then runs a single-cycle ALU op or a 16-iteration shift-add multiply.
module accumulator_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [AW-1:0]    operand_addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] out_reg,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry
);

    localparam logic [3:0] MUL_LAST = 4'(WIDTH - 1);

    state_t           r_state;
    logic [3:0]       r_opcode;
    logic [AW-1:0]    r_mem_addr;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out_reg;
    logic [WIDTH-1:0] r_product;
    logic [WIDTH-1:0] r_mcand;
    logic [3:0]       r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_zero;
    logic             r_carry;

    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic [WIDTH-1:0] w_product_next;

    accumulator_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .i_op     (r_opcode),
        .i_acc    (r_acc),
        .i_operand(r_operand),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // Only the low WIDTH bits of the product are ever kept, so the partial
    // product and the shifted multiplicand need no extra width.
    assign w_product_next = r_product + (r_operand[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_opcode   <= '0;
            r_mem_addr <= '0;
            r_operand  <= '0;
            r_acc      <= '0;
            r_out_reg  <= '0;
            r_product  <= '0;
            r_mcand    <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opcode   <= opcode;
                        r_mem_addr <= operand_addr;
                        r_busy     <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_operand <= data_in;
                    if (r_opcode == OP_MUL) begin
                        r_product <= '0;
                        r_count   <= '0;
                        r_mcand   <= r_acc;
                        r_state   <= ST_MUL;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (writesAcc(r_opcode)) begin
                        r_acc   <= w_alu_result;
                        r_zero  <= (w_alu_result == '0);
                        r_carry <= w_alu_carry;
                    end
                    if (r_opcode == OP_OUT) begin
                        r_out_reg <= r_acc;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_MUL: begin
                    r_product <= w_product_next;
                    r_mcand   <= {r_mcand[WIDTH-2:0], 1'b0};
                    r_operand <= {1'b0, r_operand[WIDTH-1:1]};
                    r_count   <= r_count + 4'd1;
                    if (r_count == MUL_LAST) begin
                        r_acc   <= w_product_next;
                        r_zero  <= (w_product_next == '0);
                        r_carry <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign acc      = r_acc;
    assign out_reg  = r_out_reg;
    assign busy     = r_busy;
    assign done     = r_done;
    assign zero     = r_zero;
    assign carry    = r_carry;

endmodule

// File: tb/tb_accumulator_unit.sv
// Scoreboard bench for accumulator_unit: a data-register model feeds operands,
// an arithmetic reference model predicts each completion, and a monitor checks it.
module tb_accumulator_unit;

    typedef struct {
        logic [15:0] accVal;
        logic [15:0] outVal;
        logic        zeroVal;
        logic        carryVal;
        logic [3:0]  addr;
        int          acceptEdge;
        int          latency;
        int          busyCycles;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  opcode;
    logic [3:0]  operand_addr;
    logic [15:0] data_in;
    logic [3:0]  mem_addr;
    logic [15:0] acc;
    logic [15:0] out_reg;
    logic        busy;
    logic        done;
    logic        zero;
    logic        carry;

    logic [15:0] mem [16];
    exp_t        expQ [$];

    int compared   = 0;
    int mismatched = 0;
    int edgeCount  = 0;
    int busyRun    = 0;

    logic [15:0] mAcc;
    logic [15:0] mOut;
    logic        mZero;
    logic        mCarry;

    accumulator_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .operand_addr(operand_addr),
        .data_in     (data_in),
        .mem_addr    (mem_addr),
        .acc         (acc),
        .out_reg     (out_reg),
        .busy        (busy),
        .done        (done),
        .zero        (zero),
        .carry       (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_in = mem[mem_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edgeCount);
        end
    endtask

    // Reference model: the architectural effect of one operation, in plain arithmetic.
    task automatic modelOp(input logic [3:0] op, input logic [15:0] v);
        int unsigned a;
        int unsigned b;
        int unsigned r;
        a = mAcc;
        b = v;
        r = a;
        case (op)
            4'h1: begin r = b; mCarry = 1'b0; end
            4'h2: begin r = a + b; mCarry = (r > 65535); end
            4'h3: begin mCarry = (a < b); r = (a + 65536 - b); end
            4'h4: begin r = a & b; mCarry = 1'b0; end
            4'h5: begin r = a | b; mCarry = 1'b0; end
            4'h6: begin r = a ^ b; mCarry = 1'b0; end
            4'h7: begin r = a * b; mCarry = 1'b0; end
            4'h8: begin mCarry = (a >= 32768); r = a * 2; end
            4'h9: begin mCarry = (a % 2 == 1); r = a / 2; end
            4'hA: mOut = mAcc;
            4'hB: begin r = 0; mCarry = 1'b0; end
            default: ;
        endcase
        if ((op >= 4'h1 && op <= 4'h9) || op == 4'hB) begin
            mAcc  = r[15:0];
            mZero = (r[15:0] == 16'h0);
        end
    endtask

    // Waits for the unit to be idle, issues one op and queues its predicted result.
    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] addr);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            mismatched++;
            $display("[TB] FAIL idleWait: busy still 1, expected 0 within 40 cycles");
            return;
        end
        start        = 1'b1;
        opcode       = op;
        operand_addr = addr;
        modelOp(op, mem[addr]);
        e.accVal     = mAcc;
        e.outVal     = mOut;
        e.zeroVal    = mZero;
        e.carryVal   = mCarry;
        e.addr       = addr;
        e.acceptEdge = edgeCount + 1;
        e.latency    = (op == 4'h7) ? 18 : 3;
        e.busyCycles = (op == 4'h7) ? 17 : 2;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d completions outstanding, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: samples just after each rising edge and scores every done pulse.
    always begin
        exp_t e;
        @(posedge clk);
        edgeCount++;
        #1;
        if (reset) begin
            busyRun = 0;
        end else begin
            if (busy) busyRun++;
            if (done) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedDone: done=1, expected 0 (nothing outstanding)");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("acc", 32'(acc), 32'(e.accVal));
                    checkOutput("out_reg", 32'(out_reg), 32'(e.outVal));
                    checkOutput("zero", 32'(zero), 32'(e.zeroVal));
                    checkOutput("carry", 32'(carry), 32'(e.carryVal));
                    checkOutput("mem_addr", 32'(mem_addr), 32'(e.addr));
                    checkOutput("latency", 32'(edgeCount - e.acceptEdge + 1), 32'(e.latency));
                    checkOutput("busyCycles", 32'(busyRun), 32'(e.busyCycles));
                    checkOutput("busyInDone", 32'(busy), 32'h0);
                end
                busyRun = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[0] = 16'd10;
        mem[1] = 16'd15;
        mem[2] = 16'd16;
        mem[3] = 16'h8001;
        mem[4] = 16'd0;
        mem[5] = 16'hFFFF;
        mem[6] = 16'd10;
        mAcc = '0; mOut = '0; mZero = 1'b0; mCarry = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        opcode = '0;
        operand_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetAcc", 32'(acc), 32'h0);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        checkOutput("resetDone", 32'(done), 32'h0);
        checkOutput("resetMemAddr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed sequence");
        applyStimulus(4'h1, 4'd0);
        applyStimulus(4'h2, 4'd1);
        applyStimulus(4'h7, 4'd2);
        applyStimulus(4'h1, 4'd0);
        applyStimulus(4'h3, 4'd1);
        applyStimulus(4'h1, 4'd0);
        applyStimulus(4'h3, 4'd6);
        applyStimulus(4'h1, 4'd3);
        applyStimulus(4'h8, 4'd0);
        applyStimulus(4'hA, 4'd0);
        applyStimulus(4'h1, 4'd5);
        applyStimulus(4'h2, 4'd5);
        applyStimulus(4'h9, 4'd0);
        applyStimulus(4'hB, 4'd0);
        applyStimulus(4'hD, 4'd7);

        $display("[TB] start ignored while MUL busy");
        applyStimulus(4'h1, 4'd1);
        applyStimulus(4'h7, 4'd2);
        repeat (3) @(negedge clk);
        start = 1'b1;
        opcode = 4'h2;
        operand_addr = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain(40);
        repeat (4) @(negedge clk);

        $display("[TB] randomized sequence");
        for (int k = 0; k < 60; k++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        waitDrain(40);

        $display("[TB] reset during MUL");
        applyStimulus(4'h1, 4'd5);
        applyStimulus(4'hA, 4'd0);
        applyStimulus(4'h7, 4'd5);
        repeat (4) @(negedge clk);
        expQ.delete();
        reset = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("midResetAcc", 32'(acc), 32'h0);
        checkOutput("midResetOut", 32'(out_reg), 32'h0);
        checkOutput("midResetBusy", 32'(busy), 32'h0);
        checkOutput("midResetMemAddr", 32'(mem_addr), 32'h0);
        checkOutput("midResetDone", 32'(done), 32'h0);
        checkOutput("midResetFlags", 32'({zero, carry}), 32'h0);
        mAcc = '0; mOut = '0; mZero = 1'b0; mCarry = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        applyStimulus(4'h2, 4'd2);
        waitDrain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
